// File: rtl/addr8s_chk_pkg.sv
// Shared types and constants for the serial sum checker.
package addr8s_chk_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

  // Bit-index counter width for a WIDTH+1 bit serial pass.
  function automatic int cnt_w(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

  // Saturation value; sliced down to the counter width by the user.
  localparam logic [63:0] ERR_SAT = '1;

endpackage

// File: rtl/addr_sub_bitcell.sv
// One-bit full subtractor: d = s - a - br_in, with borrow out.
module addr_sub_bitcell (
  input  logic s,
  input  logic a,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = s ^ a ^ br_in;
  assign br_out = (~s & a) | (~(s ^ a) & br_in);

endmodule

// File: rtl/addr8s_sum_checker.sv
// Bit-serial concurrent error detector for a signed adder: recovers O - sext(A) and compares to sext(B).
// Optional saturating error counter and err_count port enabled by macro ERR_COUNT_EN.
module addr8s_sum_checker
  import addr8s_chk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH:0]       sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_error,
  output logic [WIDTH:0]       out_syndrome,
  input  logic                 err_clr
`ifdef ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  state_t           state;
  logic [WIDTH:0]   a_sh, b_sh, s_sh, syn;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             d, br_next;
  logic [WIDTH:0]   syn_next;

  addr_sub_bitcell u_cell (
    .s      (s_sh[0]),
    .a      (a_sh[0]),
    .br_in  (br),
    .d      (d),
    .br_out (br_next)
  );

  // Syndrome fills from the top so bit 0 ends up holding the first (LSB) result.
  assign syn_next = {d ^ b_sh[0], syn[WIDTH:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_error    <= 1'b0;
      out_syndrome <= '0;
      a_sh         <= '0;
      b_sh         <= '0;
      s_sh         <= '0;
      syn          <= '0;
      cnt          <= '0;
      br           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= {a[WIDTH-1], a};
            b_sh     <= {b[WIDTH-1], b};
            s_sh     <= sum;
            syn      <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          s_sh <= s_sh >> 1;
          syn  <= syn_next;
          br   <= br_next;
          if (cnt == LAST) begin
            out_valid    <= 1'b1;
            out_error    <= |syn_next;
            out_syndrome <= syn_next;
            state        <= REPORT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REPORT: begin
          if (out_ready) begin
            out_valid    <= 1'b0;
            out_error    <= 1'b0;
            out_syndrome <= '0;
            in_ready     <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ERR_COUNT_EN
  logic report_err;
  assign report_err = (state == REPORT) && out_valid && out_ready && out_error;

  // Clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (report_err && (err_count != ERR_SAT[ERR_CNT_W-1:0])) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_addr8s_sum_checker.sv
// Scoreboard bench for addr8s_sum_checker; err_count checks active when ERR_COUNT_EN is defined.
module tb_addr8s_sum_checker;

  localparam int WIDTH = 8;
`ifdef ERR_COUNT_EN
  localparam int ERR_CNT_W = 2;
`else
  localparam int ERR_CNT_W = 16;
`endif

  typedef struct packed {
    logic           err;
    logic [WIDTH:0] syn;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     a = '0;
  logic [WIDTH-1:0]     b = '0;
  logic [WIDTH:0]       sum = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 out_error;
  logic [WIDTH:0]       out_syndrome;
  logic                 err_clr = 1'b0;
`ifdef ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] err_count;
`endif

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_err  = 0;
  localparam int ERR_MAX = (1 << ERR_CNT_W) - 1;

  always #5 clk = ~clk;

  addr8s_sum_checker #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .sum          (sum),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_error    (out_error),
    .out_syndrome (out_syndrome),
    .err_clr      (err_clr)
`ifdef ERR_COUNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic [WIDTH:0] ts);
    exp_t e;
    logic [WIDTH:0] bp;
    bp    = ts - {ta[WIDTH-1], ta};
    e.syn = bp ^ {tb_[WIDTH-1], tb_};
    e.err = |e.syn;
    return e;
  endfunction

  task automatic check_err_count(input string tag);
`ifdef ERR_COUNT_EN
    chk(tag, 32'(err_count), 32'(m_err));
`endif
  endtask

  // Present a triple and wait (bounded) for acceptance; leaves in_valid low afterwards.
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic [WIDTH:0] ts);
    int guard = 0;
    @(negedge clk);
    a = ta; b = tb_; sum = ts; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    q.push_back(model(ta, tb_, ts));
    #1 in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; counts edges with the accept edge as 1.
  task automatic collect(input string tag);
    int   lat = 1;
    exp_t e;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd10);
    if (out_valid && q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_error"}, 32'(out_error), 32'(e.err));
      chk({tag, "_syndrome"}, 32'(out_syndrome), 32'(e.syn));
      chk({tag, "_busy"}, 32'(in_ready), 32'd0);
      q.push_front(e);
    end
  endtask

  // Complete the REPORT handshake (out_ready assumed high) and update the error model.
  task automatic finish(input string tag, input logic clr);
    exp_t e;
    if (q.size() > 0) e = q.pop_front();
    else e = '0;
    @(posedge clk); #1;
    if (clr) m_err = 0;
    else if (e.err && m_err != ERR_MAX) m_err++;
    chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check_err_count({tag, "_errcnt"});
  endtask

  task automatic run(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic [WIDTH:0] ts);
    send(ta, tb_, ts);
    collect(tag);
    finish(tag, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   h_syn;
    logic             h_err;
    int               seen;

    #23 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_error", 32'(out_error), 32'd0);
    chk("rst_syndrome", 32'(out_syndrome), 32'd0);
    check_err_count("rst_errcnt");

    run("max_pos", 8'h7F, 8'h01, 9'h080);
    run("min_neg", 8'h80, 8'h80, 9'h100);
    run("neg_one", 8'hFF, 8'h01, 9'h000);
    run("fault_lsb", 8'h7F, 8'h01, 9'h081);
    run("fault_zero", 8'h7F, 8'h01, 9'h000);

    for (int i = 0; i < 16; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rs = {ra[WIDTH-1], ra} + {rb[WIDTH-1], rb};
      if ($urandom_range(2, 0) == 0) rs[$urandom_range(WIDTH, 0)] ^= 1'b1;
      run("rand", ra, rb, rs);
    end

    // Backpressure: hold the result, keep a second triple pending meanwhile.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 9'h047);
    collect("bp");
    h_err = out_error;
    h_syn = out_syndrome;
    @(negedge clk);
    a = 8'h05; b = 8'hFB; sum = 9'h000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_error", 32'(out_error), 32'(h_err));
      chk("bp_hold_syn", 32'(out_syndrome), 32'(h_syn));
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    finish("bp", 1'b0);
    @(posedge clk);
    q.push_back(model(8'h05, 8'hFB, 9'h000));
    #1 in_valid = 1'b0;
    chk("bp_second_taken", 32'(in_ready), 32'd0);
    collect("bp2");
    finish("bp2", 1'b0);

`ifdef ERR_COUNT_EN
    for (int i = 0; i < 4; i++) run("sat", 8'h10, 8'h10, 9'h021);
    chk("sat_value", 32'(err_count), 32'(ERR_MAX));
    out_ready = 1'b0;
    send(8'h01, 8'h01, 9'h003);
    collect("clr");
    @(negedge clk);
    err_clr = 1'b1;
    out_ready = 1'b1;
    finish("clr", 1'b1);
    err_clr = 1'b0;
    run("after_clr", 8'h01, 8'h01, 9'h007);
`endif

    // Asynchronous reset while bit 4 is being processed.
    run("pre_rst", 8'h01, 8'h02, 9'h004);
    send(8'h40, 8'h40, 9'h000);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_err = 0;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_error", 32'(out_error), 32'd0);
    chk("arst_syndrome", 32'(out_syndrome), 32'd0);
    check_err_count("arst_errcnt");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("arst_no_report", 32'(seen), 32'd0);
    run("post_rst", 8'hC0, 8'h20, 9'h1E0);
    run("post_rst_fault", 8'hC0, 8'h20, 9'h0E0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
